fpu_thread_arb: RTL and testbench

- Shared-FPU thread arbiter for the multithreaded CPU.
- Collects FP-op requests from NTHREADS integer units and picks one per cycle by round-robin.
- Muxes the winner's operands and control into the single FPU.
- Carries the winning thread id down a tag pipeline, then demultiplexes FPU stage write-enables and FPU stall back to the owning thread.
- Supports N threads and configurable FPU depth, and produces a per-thread "not selected" hold.

---
 rtl/fpu_thread_arb.sv | 110 +++++++++++
 tb/tb_fpu_thread_arb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_thread_arb.sv
// Shared-FPU round-robin thread arbiter with operand mux, tag pipeline and writeback/stall demux.
// Optional urgent-thread priority filter enabled by defining FPU_ARB_PRIO_EN.
module fpu_thread_arb #(
  parameter int NTHREADS = 4,
  parameter int TW       = 2,
  parameter int DEPTH    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      e,
  input  logic [NTHREADS-1:0]       req_i,
  input  logic [NTHREADS*32-1:0]    dfa_i,
  input  logic [NTHREADS*32-1:0]    dfb_i,
  input  logic [NTHREADS*3-1:0]     fc_i,
  input  logic [NTHREADS*5-1:0]     fd_i,
  input  logic [NTHREADS-1:0]       wf_i,
`ifdef FPU_ARB_PRIO_EN
  input  logic [NTHREADS-1:0]       prio_i,
`endif
  input  logic                      fpu_stall_i,
  input  logic [DEPTH-1:0]          fpu_w_i,
  output logic [31:0]               dfa_o,
  output logic [31:0]               dfb_o,
  output logic [2:0]                fc_o,
  output logic [4:0]                fd_o,
  output logic                      wf_o,
  output logic                      issue_o,
  output logic [TW-1:0]             dt_o,
  output logic [NTHREADS-1:0]       st_o,
  output logic [NTHREADS-1:0]       stall_o,
  output logic [NTHREADS*DEPTH-1:0] stage_w_o
);

  logic [TW-1:0]       rr_ptr;
  logic [NTHREADS-1:0] cand;
  logic [DEPTH-1:0]    tag_v;
  logic [TW-1:0]       tag_tid [DEPTH];

`ifdef FPU_ARB_PRIO_EN
  assign cand = (|(req_i & prio_i)) ? (req_i & prio_i) : req_i;
`else
  assign cand = req_i;
`endif

  // Scan from the farthest offset down so the nearest requester to rr_ptr is written last.
  always_comb begin
    issue_o = 1'b0;
    dt_o    = '0;
    for (int i = NTHREADS - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NTHREADS;
      if (cand[idx]) begin
        issue_o = 1'b1;
        dt_o    = TW'(idx);
      end
    end
  end

  always_comb begin
    dfa_o = '0;
    dfb_o = '0;
    fc_o  = '0;
    fd_o  = '0;
    wf_o  = 1'b0;
    if (issue_o) begin
      dfa_o = dfa_i[int'(dt_o)*32 +: 32];
      dfb_o = dfb_i[int'(dt_o)*32 +: 32];
      fc_o  = fc_i[int'(dt_o)*3 +: 3];
      fd_o  = fd_i[int'(dt_o)*5 +: 5];
      wf_o  = wf_i[dt_o];
    end
  end

  always_comb begin
    st_o    = '0;
    stall_o = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      st_o[t]    = req_i[t] & ~(issue_o & (dt_o == TW'(t)));
      stall_o[t] = fpu_stall_i & issue_o & (dt_o == TW'(t));
    end
  end

  always_comb begin
    stage_w_o = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_w_o[t*DEPTH+k] = fpu_w_i[k] & tag_v[k] & (tag_tid[k] == TW'(t));
      end
    end
  end

  // A stalled grant neither advances the pointer nor launches a valid tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      tag_v  <= '0;
      for (int k = 0; k < DEPTH; k++) tag_tid[k] <= '0;
    end else if (e) begin
      if (issue_o && !fpu_stall_i)
        rr_ptr <= (dt_o == TW'(NTHREADS - 1)) ? '0 : dt_o + TW'(1);
      tag_v[0]   <= issue_o & ~fpu_stall_i;
      tag_tid[0] <= dt_o;
      for (int k = 1; k < DEPTH; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_tid[k] <= tag_tid[k-1];
      end
    end
  end

endmodule

// File: tb/tb_fpu_thread_arb.sv
// Directed self-checking bench for fpu_thread_arb (N=4, DEPTH=4).
module tb_fpu_thread_arb;
  localparam int N = 4;
  localparam int D = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            e;
  logic [N-1:0]    req_i;
  logic [N*32-1:0] dfa_i, dfb_i;
  logic [N*3-1:0]  fc_i;
  logic [N*5-1:0]  fd_i;
  logic [N-1:0]    wf_i;
`ifdef FPU_ARB_PRIO_EN
  logic [N-1:0]    prio_i;
`endif
  logic            fpu_stall_i;
  logic [D-1:0]    fpu_w_i;
  logic [31:0]     dfa_o, dfb_o;
  logic [2:0]      fc_o;
  logic [4:0]      fd_o;
  logic            wf_o, issue_o;
  logic [1:0]      dt_o;
  logic [N-1:0]    st_o, stall_o;
  logic [N*D-1:0]  stage_w_o;

  int n_cmp = 0;
  int n_err = 0;

  fpu_thread_arb #(.NTHREADS(N), .TW(2), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .e(e), .req_i(req_i),
    .dfa_i(dfa_i), .dfb_i(dfb_i), .fc_i(fc_i), .fd_i(fd_i), .wf_i(wf_i),
`ifdef FPU_ARB_PRIO_EN
    .prio_i(prio_i),
`endif
    .fpu_stall_i(fpu_stall_i), .fpu_w_i(fpu_w_i),
    .dfa_o(dfa_o), .dfb_o(dfb_o), .fc_o(fc_o), .fd_o(fd_o), .wf_o(wf_o),
    .issue_o(issue_o), .dt_o(dt_o), .st_o(st_o), .stall_o(stall_o),
    .stage_w_o(stage_w_o)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; e = 1'b1; req_i = '0; fpu_stall_i = 1'b0; fpu_w_i = '0;
    wf_i = 4'b1010;
`ifdef FPU_ARB_PRIO_EN
    prio_i = '0;
`endif
    for (int t = 0; t < N; t++) begin
      dfa_i[t*32 +: 32] = 32'hA000_0000 | t;
      dfb_i[t*32 +: 32] = 32'hB000_0000 | t;
      fc_i[t*3 +: 3]    = 3'(t + 1);
      fd_i[t*5 +: 5]    = 5'(t + 10);
    end
    tick(); tick();
    reset = 1'b0;
    #1;
    check_val("rst_issue", 32'(issue_o), 32'h0);
    check_val("rst_st", 32'(st_o), 32'h0);
    check_val("rst_dfa", dfa_o, 32'h0);
    fpu_w_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1 check_val("rst_stage_w", 32'(stage_w_o), 32'h0);
      tick();
    end

    // full round robin, rr_ptr starts at 0
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_val("rr_dt", 32'(dt_o), 32'(i % 4));
      check_val("rr_st", 32'(st_o), 32'(4'b1111 & ~(4'b0001 << (i % 4))));
      check_val("rr_dfa", dfa_o, 32'hA000_0000 | (i % 4));
      check_val("rr_fd", 32'(fd_o), 32'((i % 4) + 10));
      check_val("rr_wf", 32'(wf_o), 32'((i % 4) & 1));
      tick();
    end
    req_i = '0;
    repeat (4) tick();
    check_val("flush_stage_w", 32'(stage_w_o), 32'h0);

    // single issue from thread 2 walks down its stage bits
    req_i = 4'b0100;
    #1 check_val("t2_dt", 32'(dt_o), 32'd2);
    tick();
    req_i = '0;
    for (int k = 0; k < 4; k++) begin
      #1 check_val("t2_stage_w", 32'(stage_w_o), 32'h1 << (8 + k));
      tick();
    end
    #1 check_val("t2_drained", 32'(stage_w_o), 32'h0);

    // thread 3 issue brings rr_ptr back to 0, then stall with 0101
    req_i = 4'b1000;
    tick();
    req_i = 4'b0101; fpu_stall_i = 1'b1; fpu_w_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("stall_dt", 32'(dt_o), 32'd0);
      check_val("stall_o", 32'(stall_o), 32'h1);
      check_val("stall_st", 32'(st_o), 32'h4);
      check_val("stall_stage_w", 32'(stage_w_o), (i == 0) ? 32'h1000 : 32'h0);
      tick();
    end
    fpu_stall_i = 1'b0;
    #1;
    check_val("unstall_dt0", 32'(dt_o), 32'd0);
    check_val("unstall_stall_o", 32'(stall_o), 32'h0);
    check_val("unstall_stage_w0", 32'(stage_w_o), 32'h0);
    tick();
    #1;
    check_val("unstall_dt1", 32'(dt_o), 32'd2);
    check_val("unstall_stage_w1", 32'(stage_w_o), 32'h1);
    tick();
    req_i = '0;
    #1 check_val("unstall_stage_w2", 32'(stage_w_o), 32'h100);
    repeat (4) tick();

    // rr_ptr=3: issue thread 1, then freeze with e=0
    req_i = 4'b0010;
    #1 check_val("frz_dt1", 32'(dt_o), 32'd1);
    tick();
    req_i = 4'b1001; e = 1'b0; fpu_w_i = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_val("frz_dt", 32'(dt_o), 32'd3);
      check_val("frz_st", 32'(st_o), 32'h1);
      check_val("frz_stage_w", 32'(stage_w_o), 32'h10);
      tick();
    end
    e = 1'b1;
    #1 check_val("frz_no_adv", 32'(dt_o), 32'd3);
    tick();
    req_i = '0; fpu_w_i = 4'b0011;
    #1 check_val("unfrz_stage_w", 32'(stage_w_o), 32'h1020);

    // reset mid-flight drops writebacks and rr_ptr
    repeat (4) tick();
    req_i = 4'b0010;
    #1 check_val("pre_rst_dt", 32'(dt_o), 32'd1);
    tick();
    req_i = '0; reset = 1'b1;
    tick();
    reset = 1'b0; fpu_w_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1 check_val("midrst_stage_w", 32'(stage_w_o), 32'h0);
      tick();
    end
    req_i = 4'b1111;
    #1 check_val("midrst_ptr", 32'(dt_o), 32'd0);

    req_i = 4'b1011;
`ifdef FPU_ARB_PRIO_EN
    prio_i = 4'b1000;
    #1 check_val("prio_dt", 32'(dt_o), 32'd3);
    prio_i = 4'b0000;
`endif
    #1 check_val("noprio_dt", 32'(dt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
